// File: rtl/m3_drive_sequencer_if.sv
// rtl/m3_drive_sequencer_if.sv - operator controls and drive setpoint bundle for the 3-phase run controller
interface m3_drive_sequencer_if #(
    parameter int FREQ_W = 16,
    parameter int PWR_W  = 8
);
    logic              m3startI;
    logic              m3forceStopI;
    logic              m3invRotateI;
    logic              m3freqINCi;
    logic              m3freqDECi;
    logic              m3powerINCi;
    logic              m3powerDECi;
    logic              m3runO;
    logic              m3dirO;
    logic [FREQ_W-1:0] m3freqO;
    logic [PWR_W-1:0]  m3powerO;
    logic [3:0]        m3stepO;
    logic              m3stepStbO;
    logic [2:0]        m3stateO;

    modport master (
        output m3startI, m3forceStopI, m3invRotateI,
        output m3freqINCi, m3freqDECi, m3powerINCi, m3powerDECi,
        input  m3runO, m3dirO, m3freqO, m3powerO, m3stepO, m3stepStbO, m3stateO
    );

    modport slave (
        input  m3startI, m3forceStopI, m3invRotateI,
        input  m3freqINCi, m3freqDECi, m3powerINCi, m3powerDECi,
        output m3runO, m3dirO, m3freqO, m3powerO, m3stepO, m3stepStbO, m3stateO
    );
endinterface

// File: rtl/m3_drive_sequencer.sv
// rtl/m3_drive_sequencer.sv - soft start/stop, reversal and force-stop sequencer producing freq/power setpoints and 12-step commutation
module m3_drive_sequencer #(
    parameter int FREQ_W    = 16,
    parameter int PWR_W     = 8,
    parameter int ACC_W     = 24,
    parameter int FREQ_MIN  = 100,
    parameter int FREQ_MAX  = 4000,
    parameter int FREQ_STEP = 10,
    parameter int PWR_MIN   = 32,
    parameter int PWR_MAX   = 250,
    parameter int PWR_STEP  = 4,
    parameter int RAMP_DIV  = 1000
) (
    input  logic               clkI,
    input  logic               nRstI,
    m3_drive_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RAMP_UP = 3'd1,
        ST_RUN     = 3'd2,
        ST_RAMP_DN = 3'd3,
        ST_FSTOP   = 3'd4
    } state_t;

    localparam int PW = $clog2(RAMP_DIV);
    localparam logic [FREQ_W-1:0] F_MIN  = FREQ_W'(FREQ_MIN);
    localparam logic [FREQ_W-1:0] F_MAX  = FREQ_W'(FREQ_MAX);
    localparam logic [FREQ_W-1:0] F_STEP = FREQ_W'(FREQ_STEP);
    localparam logic [PWR_W-1:0]  P_MIN  = PWR_W'(PWR_MIN);
    localparam logic [PWR_W-1:0]  P_MAX  = PWR_W'(PWR_MAX);
    localparam logic [PWR_W-1:0]  P_STEP = PWR_W'(PWR_STEP);
    localparam logic [PW-1:0]     PRESC_LAST = PW'(RAMP_DIV - 1);

    state_t            state_q, state_d;
    logic              dir_q, dir_d;
    logic              rev_pend_q, rev_pend_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic [FREQ_W-1:0] freq_tgt_q, freq_tgt_d;
    logic [PWR_W-1:0]  pwr_q, pwr_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [3:0]        step_q, step_d;
    logic              stb_q, stb_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [4:0]        key_q, key_d;

    logic [4:0]        keys, key_edge;
    logic              inv_edge, finc, fdec, pinc, pdec;
    logic              tick, running, start, force_stop;
    logic [ACC_W:0]    acc_sum;
    logic [3:0]        step_next;
    logic [FREQ_W-1:0] freq_up, freq_dn_tgt, freq_run, freq_dn_min;

    assign keys       = {bus.m3invRotateI, bus.m3freqINCi, bus.m3freqDECi, bus.m3powerINCi, bus.m3powerDECi};
    assign key_edge   = keys & ~key_q;
    assign {inv_edge, finc, fdec, pinc, pdec} = key_edge;
    assign start      = bus.m3startI;
    assign force_stop = bus.m3forceStopI;
    assign tick       = (presc_q == PRESC_LAST);
    assign running    = (state_q == ST_RAMP_UP) || (state_q == ST_RUN) || (state_q == ST_RAMP_DN);

    assign acc_sum   = {1'b0, acc_q} + (ACC_W+1)'(freq_q);
    assign step_next = dir_q ? ((step_q == 4'd1) ? 4'd12 : step_q - 4'd1)
                             : ((step_q == 4'd12) ? 4'd1 : step_q + 4'd1);

    // Ramp candidates are clamped against the target so a ramp never overshoots it.
    assign freq_up     = ((freq_q >= freq_tgt_q) || (freq_tgt_q - freq_q <= F_STEP)) ? freq_tgt_q : freq_q + F_STEP;
    assign freq_dn_tgt = (freq_q - freq_tgt_q <= F_STEP) ? freq_tgt_q : freq_q - F_STEP;
    assign freq_run    = (freq_q <= freq_tgt_q) ? freq_up : freq_dn_tgt;
    assign freq_dn_min = (freq_q >= F_MIN + F_STEP) ? freq_q - F_STEP : F_MIN;

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        rev_pend_d = rev_pend_q;
        freq_d     = freq_q;
        freq_tgt_d = freq_tgt_q;
        pwr_d      = pwr_q;
        acc_d      = acc_q;
        step_d     = step_q;
        stb_d      = 1'b0;
        presc_d    = tick ? '0 : presc_q + PW'(1);
        key_d      = keys;

        if (running) begin
            acc_d = acc_sum[ACC_W-1:0];
            if (acc_sum[ACC_W]) begin
                stb_d  = 1'b1;
                step_d = step_next;
            end
        end

        if (state_q != ST_FSTOP && !force_stop) begin
            if (finc && !fdec)
                freq_tgt_d = (freq_tgt_q > F_MAX - F_STEP) ? F_MAX : freq_tgt_q + F_STEP;
            else if (fdec && !finc)
                freq_tgt_d = (freq_tgt_q < F_MIN + F_STEP) ? F_MIN : freq_tgt_q - F_STEP;
            if (pinc && !pdec)
                pwr_d = (pwr_q > P_MAX - P_STEP) ? P_MAX : pwr_q + P_STEP;
            else if (pdec && !pinc)
                pwr_d = (pwr_q < P_MIN + P_STEP) ? P_MIN : pwr_q - P_STEP;
        end

        if (force_stop) begin
            state_d    = ST_FSTOP;
            freq_d     = '0;
            step_d     = '0;
            stb_d      = 1'b0;
            rev_pend_d = 1'b0;
            acc_d      = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (inv_edge) begin
                        dir_d = ~dir_q;
                    end else if (start) begin
                        state_d = ST_RAMP_UP;
                        freq_d  = F_MIN;
                        step_d  = 4'd1;
                        acc_d   = '0;
                    end
                end
                ST_RAMP_UP, ST_RUN: begin
                    if (inv_edge) begin
                        rev_pend_d = 1'b1;
                        state_d    = ST_RAMP_DN;
                    end else if (!start) begin
                        state_d = ST_RAMP_DN;
                    end else if (tick) begin
                        if (state_q == ST_RAMP_UP) begin
                            freq_d = freq_up;
                            if (freq_up == freq_tgt_q) state_d = ST_RUN;
                        end else begin
                            freq_d = freq_run;
                        end
                    end
                end
                ST_RAMP_DN: begin
                    if (inv_edge) begin
                        rev_pend_d = ~rev_pend_q;
                    end else if (tick) begin
                        if (freq_q == F_MIN) begin
                            if (rev_pend_q) begin
                                dir_d      = ~dir_q;
                                rev_pend_d = 1'b0;
                            end
                            if (start) begin
                                state_d = ST_RAMP_UP;
                            end else begin
                                state_d = ST_IDLE;
                                freq_d  = '0;
                                step_d  = '0;
                                stb_d   = 1'b0;
                                acc_d   = '0;
                            end
                        end else begin
                            freq_d = freq_dn_min;
                        end
                    end
                end
                ST_FSTOP: begin
                    if (!start) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clkI) begin
        if (!nRstI) begin
            state_q    <= ST_IDLE;
            dir_q      <= 1'b0;
            rev_pend_q <= 1'b0;
            freq_q     <= '0;
            freq_tgt_q <= F_MIN;
            pwr_q      <= P_MIN;
            acc_q      <= '0;
            step_q     <= '0;
            stb_q      <= 1'b0;
            presc_q    <= '0;
            key_q      <= '0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            rev_pend_q <= rev_pend_d;
            freq_q     <= freq_d;
            freq_tgt_q <= freq_tgt_d;
            pwr_q      <= pwr_d;
            acc_q      <= acc_d;
            step_q     <= step_d;
            stb_q      <= stb_d;
            presc_q    <= presc_d;
            key_q      <= key_d;
        end
    end

    assign bus.m3runO     = running;
    assign bus.m3dirO     = dir_q;
    assign bus.m3freqO    = freq_q;
    assign bus.m3powerO   = running ? pwr_q : '0;
    assign bus.m3stepO    = step_q;
    assign bus.m3stepStbO = stb_q;
    assign bus.m3stateO   = state_q;
endmodule

// File: tb/tb_m3_drive_sequencer.sv
// tb/tb_m3_drive_sequencer.sv - directed self-checking bench for the drive sequencer
module tb_m3_drive_sequencer;
    logic clk = 1'b0;
    logic n_rst;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    m3_drive_sequencer_if #(.FREQ_W(16), .PWR_W(8)) bus ();

    m3_drive_sequencer #(
        .FREQ_W(16), .PWR_W(8), .ACC_W(6),
        .FREQ_MIN(4), .FREQ_MAX(20), .FREQ_STEP(4),
        .PWR_MIN(8), .PWR_MAX(16), .PWR_STEP(4),
        .RAMP_DIV(4)
    ) dut (
        .clkI  (clk),
        .nRstI (n_rst),
        .bus   (bus)
    );

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // m = {inv, freqINC, freqDEC, powerINC, powerDEC}
    task automatic key(input logic [4:0] m);
        {bus.m3invRotateI, bus.m3freqINCi, bus.m3freqDECi, bus.m3powerINCi, bus.m3powerDECi} = m;
        clk1();
        {bus.m3invRotateI, bus.m3freqINCi, bus.m3freqDECi, bus.m3powerINCi, bus.m3powerDECi} = 5'b0;
        clk1();
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
        for (int i = 0; i < budget && bus.m3stateO !== s; i++) clk1();
        chk(tag, 32'(bus.m3stateO), 32'(s));
    endtask

    task automatic wait_freq(input string tag, input logic [15:0] f, input int budget);
        for (int i = 0; i < budget && bus.m3freqO !== f; i++) clk1();
        chk(tag, 32'(bus.m3freqO), 32'(f));
    endtask

    task automatic check_steps(input string tag, input bit rev, input int n);
        int gap;
        logic [3:0] exp_s;
        gap = 0;
        while (bus.m3stepStbO !== 1'b1 && gap < 20) begin
            clk1();
            gap++;
        end
        chk({tag, "_sync"}, 32'(bus.m3stepStbO), 32'd1);
        exp_s = bus.m3stepO;
        for (int i = 0; i < n; i++) begin
            gap = 0;
            do begin
                clk1();
                gap++;
            end while (bus.m3stepStbO !== 1'b1 && gap < 20);
            exp_s = rev ? ((exp_s == 4'd1) ? 4'd12 : exp_s - 4'd1)
                        : ((exp_s == 4'd12) ? 4'd1 : exp_s + 4'd1);
            chk({tag, "_gap"}, 32'(gap), 32'd4);
            chk({tag, "_step"}, 32'(bus.m3stepO), 32'(exp_s));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, 32'(bus.m3stateO), 32'd0);
        chk({tag, "_freq"},  32'(bus.m3freqO),  32'd0);
        chk({tag, "_power"}, 32'(bus.m3powerO), 32'd0);
        chk({tag, "_step"},  32'(bus.m3stepO),  32'd0);
        chk({tag, "_run"},   32'(bus.m3runO),   32'd0);
        chk({tag, "_stb"},   32'(bus.m3stepStbO), 32'd0);
    endtask

    initial begin
        int gap;
        n_rst = 1'b0;
        bus.m3startI = 1'b0;
        bus.m3forceStopI = 1'b0;
        {bus.m3invRotateI, bus.m3freqINCi, bus.m3freqDECi, bus.m3powerINCi, bus.m3powerDECi} = 5'b0;
        clk1();
        clk1();
        chk_all_zero("reset");
        chk("reset_dir", 32'(bus.m3dirO), 32'd0);
        n_rst = 1'b1;

        // Target ends at 12 only if DEC saturated at 4 and INC+DEC did nothing.
        key(5'b00100);
        key(5'b01100);
        key(5'b01000);
        key(5'b01000);

        // T1 soft start
        bus.m3startI = 1'b1;
        clk1();
        chk("t1_state", 32'(bus.m3stateO), 32'd1);
        chk("t1_freq0", 32'(bus.m3freqO), 32'd4);
        chk("t1_step0", 32'(bus.m3stepO), 32'd1);
        chk("t1_run",   32'(bus.m3runO),  32'd1);
        chk("t1_power", 32'(bus.m3powerO), 32'd8);
        wait_freq("t1_freq8", 16'd8, 8);
        gap = 0;
        while (bus.m3freqO === 16'd8 && gap < 10) begin
            clk1();
            gap++;
        end
        chk("t1_tick_gap", 32'(gap), 32'd4);
        chk("t1_freq12", 32'(bus.m3freqO), 32'd12);
        wait_state("t1_run_state", 3'd2, 4);

        // T5 power keys saturate, INC+DEC together is a no-op
        key(5'b00010); chk("t5_pinc1", 32'(bus.m3powerO), 32'd12);
        key(5'b00010); chk("t5_pinc2", 32'(bus.m3powerO), 32'd16);
        key(5'b00010); chk("t5_pinc3", 32'(bus.m3powerO), 32'd16);
        key(5'b00010); chk("t5_pinc4", 32'(bus.m3powerO), 32'd16);
        key(5'b00010); chk("t5_pinc5", 32'(bus.m3powerO), 32'd16);
        key(5'b00011); chk("t5_pboth", 32'(bus.m3powerO), 32'd16);
        key(5'b00001); chk("t5_pdec",  32'(bus.m3powerO), 32'd12);

        // T2 forward commutation at freq 16
        key(5'b01000);
        wait_freq("t2_freq16", 16'd16, 8);
        chk("t2_state", 32'(bus.m3stateO), 32'd2);
        check_steps("t2", 1'b0, 13);

        // T3 reversal through minimum speed
        key(5'b10000);
        chk("t3_rampdn", 32'(bus.m3stateO), 32'd3);
        for (int i = 0; i < 40 && bus.m3dirO !== 1'b1; i++) clk1();
        chk("t3_dir", 32'(bus.m3dirO), 32'd1);
        chk("t3_state_up", 32'(bus.m3stateO), 32'd1);
        chk("t3_freq_min", 32'(bus.m3freqO), 32'd4);
        wait_state("t3_run_again", 3'd2, 40);
        chk("t3_freq16", 32'(bus.m3freqO), 32'd16);
        check_steps("t3", 1'b1, 13);

        // T6 restart request during ramp-down
        bus.m3startI = 1'b0;
        clk1();
        chk("t6_rampdn", 32'(bus.m3stateO), 32'd3);
        wait_freq("t6_freq8", 16'd8, 20);
        bus.m3startI = 1'b1;
        for (int i = 0; i < 20 && bus.m3stateO === 3'd3; i++) clk1();
        chk("t6_to_rampup", 32'(bus.m3stateO), 32'd1);
        chk("t6_freq", 32'(bus.m3freqO), 32'd4);
        chk("t6_dir",  32'(bus.m3dirO), 32'd1);

        // T4 force stop mid ramp-up, no auto restart
        bus.m3forceStopI = 1'b1;
        clk1();
        chk("t4_state", 32'(bus.m3stateO), 32'd4);
        chk("t4_freq",  32'(bus.m3freqO),  32'd0);
        chk("t4_power", 32'(bus.m3powerO), 32'd0);
        chk("t4_step",  32'(bus.m3stepO),  32'd0);
        chk("t4_run",   32'(bus.m3runO),   32'd0);
        bus.m3forceStopI = 1'b0;
        clk1(); clk1(); clk1();
        chk("t4_hold", 32'(bus.m3stateO), 32'd4);
        bus.m3startI = 1'b0;
        clk1();
        chk("t4_idle", 32'(bus.m3stateO), 32'd0);

        key(5'b10000);
        chk("idle_inv_dir", 32'(bus.m3dirO), 32'd0);

        // Synchronous reset mid-RUN
        bus.m3startI = 1'b1;
        wait_state("rst_run", 3'd2, 80);
        n_rst = 1'b0;
        clk1();
        chk_all_zero("midrst");
        n_rst = 1'b1;
        bus.m3startI = 1'b0;
        clk1();
        chk("post_rst_idle", 32'(bus.m3stateO), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
